// File: rtl/comm_pkg.sv
// Shared types and helpers for the MazeRunner command link.
// State encoding, UART frame size and checksum accumulation.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    CHK,
    DONE
  } state_e;

  localparam int UART_BITS = 10;

  function automatic logic [7:0] chk_add(
    input logic [7:0] sum,
    input logic [7:0] b
  );
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, stop bit.
// tx_done pulses in the last clock of the stop bit.
module uart_tx_core
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);

  logic [UART_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  assign tick    = busy_q && (baud_q == BW'(BAUD_DIV - 1));
  assign tx_done = tick && (bit_q == 4'(UART_BITS - 1));
  // Idle shifter holds all ones, so the line idles high.
  assign TX      = shift_q[0];

  always_comb begin
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    if (trmt && !busy_q) begin
      shift_d = {1'b1, tx_data, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (tick) begin
        baud_d  = '0;
        shift_d = {1'b1, shift_q[UART_BITS-1:1]};
        bit_d   = bit_q + 4'd1;
        if (tx_done) busy_d = 1'b0;
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered multi-byte command transmitter, MSB byte first.
// Define CHKSUM_EN to append a one's-complement checksum byte.
module uart_frame_tx
  import comm_pkg::*;
#(
  parameter  int NUM_BYTES  = 2,
  parameter  int FIFO_DEPTH = 2,
  parameter  int BAUD_DIV   = 2604,
  localparam int CMD_W      = 8 * NUM_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic             snd_cmd,
  output logic             cmd_rdy,
  output logic             TX,
  output logic             busy,
  output logic             cmd_cmplt,
  output logic             ovfl
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             ovfl_q, ovfl_d;
  logic             push, pop;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] frame_q, frame_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       data_q, data_d;
  logic             tx_done;
`ifdef CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
  logic             go_q, go_d;
`endif

  assign push      = snd_cmd & rdy_q;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);
  assign cmd_rdy   = rdy_q;
  assign ovfl      = ovfl_q;
  assign busy      = (state_q != IDLE) || (cnt_q != '0);
  assign cmd_cmplt = (state_q == DONE);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ovfl_d = ovfl_q | (snd_cmd & ~rdy_q);
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rdy_d = (cnt_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= cmd;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    trmt_d  = 1'b0;
    data_d  = data_q;
`ifdef CHKSUM_EN
    chk_d   = chk_q;
    go_d    = go_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          frame_d = mem_q[rd_q];
          idx_d   = IW'(NUM_BYTES - 1);
          state_d = LOAD;
`ifdef CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      LOAD: begin
        data_d  = 8'(frame_q >> {idx_q, 3'b000});
        trmt_d  = 1'b1;
        state_d = SEND;
`ifdef CHKSUM_EN
        chk_d   = chk_add(chk_q, data_d);
`endif
      end
      SEND: begin
        if (tx_done) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            state_d = LOAD;
          end else begin
`ifdef CHKSUM_EN
            go_d    = 1'b1;
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
      CHK: begin
`ifdef CHKSUM_EN
        // First CHK cycle mirrors LOAD so the byte spacing stays uniform.
        if (go_q) begin
          data_d = ~chk_q;
          trmt_d = 1'b1;
          go_d   = 1'b0;
        end
        if (tx_done) state_d = DONE;
`else
        state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      ovfl_q  <= 1'b0;
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      trmt_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      ovfl_q  <= ovfl_d;
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      trmt_q  <= trmt_d;
      data_q  <= data_d;
    end
  end

`ifdef CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
      go_q  <= 1'b0;
    end else begin
      chk_q <= chk_d;
      go_q  <= go_d;
    end
  end
`endif

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt_q),
    .tx_data (data_q),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: line decoder plus byte-queue reference model.
// Covers 2-byte and 4-byte builds, FIFO full/drop and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int BD = 4;
`ifdef CHKSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif
  localparam int BYTE_T = 10 * BD + 2;
  localparam int FRAME2 = (2 + XB) * BYTE_T + 2;
  localparam int FRAME4 = (4 + XB) * BYTE_T + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_rdy, TX, busy, cmd_cmplt, ovfl;
  logic [31:0] cmd4;
  logic        snd4;
  logic        rdy4, tx4, busy4, cmplt4, ovfl4;
  logic        sel4 = 1'b0;
  logic        m_tx, m_busy, m_cmplt;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .NUM_BYTES (2), .FIFO_DEPTH (2), .BAUD_DIV (BD)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cmd (cmd), .snd_cmd (snd_cmd),
    .cmd_rdy (cmd_rdy), .TX (TX), .busy (busy),
    .cmd_cmplt (cmd_cmplt), .ovfl (ovfl)
  );

  uart_frame_tx #(
    .NUM_BYTES (4), .FIFO_DEPTH (2), .BAUD_DIV (BD)
  ) dut4 (
    .clk (clk), .rst_n (rst_n), .cmd (cmd4), .snd_cmd (snd4),
    .cmd_rdy (rdy4), .TX (tx4), .busy (busy4),
    .cmd_cmplt (cmplt4), .ovfl (ovfl4)
  );

  assign m_tx    = sel4 ? tx4 : TX;
  assign m_busy  = sel4 ? busy4 : busy;
  assign m_cmplt = sel4 ? cmplt4 : cmd_cmplt;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int cmplt_n = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  // Reference: bytes MSB first, then ~(sum mod 256) when enabled.
  task automatic expect_cmd(input logic [31:0] c, input int nb);
    logic [7:0] s;
    s = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      exp_q.push_back(c[8*i +: 8]);
      s = s + c[8*i +: 8];
    end
`ifdef CHKSUM_EN
    exp_q.push_back(~s);
`endif
  endtask

  always @(negedge clk) if (m_cmplt) cmplt_n++;
  always @(negedge rst_n) rst_cnt++;

  logic [7:0] mon_b;
  logic [8:0] mon_e;
  logic       mon_sb, mon_pb;
  int         mon_r0;

  always begin
    @(negedge clk);
    if (rst_n && !m_tx) begin
      mon_r0 = rst_cnt;
      repeat (BD / 2) @(negedge clk);
      mon_sb = m_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        mon_b[i] = m_tx;
      end
      repeat (BD) @(negedge clk);
      mon_pb = m_tx;
      if (rst_n && rst_cnt == mon_r0) begin
        if (exp_q.size() != 0) mon_e = {1'b0, exp_q.pop_front()};
        else mon_e = 9'h100;
        check_eq("start_bit", 32'(mon_sb), 32'd0);
        check_eq("stop_bit", 32'(mon_pb), 32'd1);
        check_eq("byte", 32'(mon_b), 32'(mon_e));
      end
    end
  end

  task automatic frame_timing(input string tag, input int flen);
    int ks, kc, ke;
    ks = -1; kc = -1; ke = -1;
    for (int k = 1; k <= flen + 200 && ke < 0; k++) begin
      step();
      if (ks < 0 && !m_tx) ks = k;
      if (kc < 0 && m_cmplt) kc = k;
      if (!m_busy) ke = k;
    end
    check_eq({tag, "_start"}, ks, 3);
    check_eq({tag, "_cmplt"}, kc, flen - 1);
    check_eq({tag, "_len"}, ke, flen);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    for (int k = 0; k < lim && m_busy; k++) step();
    check_eq({tag, "_idle"}, 32'(m_busy), 32'd0);
    repeat (4) step();
    check_eq({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int c0, n1, p;
    logic [31:0] c, c2;
    snd_cmd = 1'b0; cmd = '0;
    snd4 = 1'b0; cmd4 = '0;
    step(); step();
    check_eq("rst_tx", 32'(TX), 32'd1);
    check_eq("rst_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmplt", 32'(cmd_cmplt), 32'd0);
    check_eq("rst_ovfl", 32'(ovfl), 32'd0);
    rst_n = 1'b1;
    repeat (100) step();
    check_eq("idle_tx", 32'(TX), 32'd1);
    check_eq("idle_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_cmplt", cmplt_n, 0);

    // Single frame with exact timing
    c0 = cmplt_n;
    expect_cmd(32'hA55A, 2);
    snd_cmd = 1'b1; cmd = 16'hA55A; step(); snd_cmd = 1'b0;
    frame_timing("a55a", FRAME2);
    repeat (4) step();
    check_eq("a55a_left", exp_q.size(), 0);
    check_eq("a55a_ncmplt", cmplt_n - c0, 1);

    // Fill FIFO behind an in-flight frame, overflow, write across pop edge
    c0 = cmplt_n;
    expect_cmd(32'h1234, 2);
    snd_cmd = 1'b1; cmd = 16'h1234; step(); snd_cmd = 1'b0;
    n1 = ncyc;
    p  = n1 + FRAME2 + 1;
    repeat (4) step();
    check_eq("rdy_inflight", 32'(cmd_rdy), 32'd1);
    expect_cmd(32'hBEEF, 2);
    expect_cmd(32'h5A5A, 2);
    snd_cmd = 1'b1; cmd = 16'hBEEF; step();
    cmd = 16'h5A5A; step();
    check_eq("rdy_full", 32'(cmd_rdy), 32'd0);
    cmd = 16'h0F0F; step();
    check_eq("ovfl_set", 32'(ovfl), 32'd1);
    while (ncyc < p - 1) step();
    check_eq("rdy_pre_pop", 32'(cmd_rdy), 32'd0);
    step();
    check_eq("rdy_post_pop", 32'(cmd_rdy), 32'd1);
    expect_cmd(32'h7777, 2);
    cmd = 16'h7777; step();
    check_eq("rdy_refull", 32'(cmd_rdy), 32'd0);
    snd_cmd = 1'b0;
    wait_idle("burst", 6 * FRAME2);
    check_eq("burst_ncmplt", cmplt_n - c0, 4);
    check_eq("ovfl_sticky", 32'(ovfl), 32'd1);

    // Random single and back-to-back pairs
    for (int it = 0; it < 6; it++) begin
      c0 = cmplt_n;
      c = 32'($urandom_range(0, 65535));
      expect_cmd(c, 2);
      snd_cmd = 1'b1; cmd = c[15:0]; step();
      check_eq("rnd_rdy1", 32'(cmd_rdy), 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        c2 = 32'($urandom_range(0, 65535));
        expect_cmd(c2, 2);
        cmd = c2[15:0]; step();
        check_eq("rnd_rdy2", 32'(cmd_rdy), 32'd1);
        snd_cmd = 1'b0;
        wait_idle("rnd2", 3 * FRAME2);
        check_eq("rnd2_ncmplt", cmplt_n - c0, 2);
      end else begin
        snd_cmd = 1'b0;
        wait_idle("rnd1", 2 * FRAME2);
        check_eq("rnd1_ncmplt", cmplt_n - c0, 1);
      end
    end

    // Reset during data bit 3 of the first byte
    c = 32'($urandom_range(0, 65535)) & 32'h0000F7FF;
    expect_cmd(c, 2);
    snd_cmd = 1'b1; cmd = c[15:0]; step(); snd_cmd = 1'b0;
    n1 = ncyc;
    while (ncyc < n1 + 3 + 4 * BD + 1) step();
    check_eq("bit3_low", 32'(TX), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_tx", 32'(TX), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("arst_ovfl", 32'(ovfl), 32'd0);
    exp_q.delete();
    c0 = cmplt_n;
    step(); step();
    rst_n = 1'b1;
    repeat (60) step();
    check_eq("arst_nocmplt", cmplt_n - c0, 0);
    check_eq("arst_idle_tx", 32'(TX), 32'd1);
    expect_cmd(32'h00FF, 2);
    snd_cmd = 1'b1; cmd = 16'h00FF; step(); snd_cmd = 1'b0;
    frame_timing("x00ff", FRAME2);
    repeat (4) step();
    check_eq("x00ff_left", exp_q.size(), 0);
    check_eq("x00ff_ncmplt", cmplt_n - c0, 1);

    // Four-byte build
    sel4 = 1'b1;
    step();
    c0 = cmplt_n;
    expect_cmd(32'h01020304, 4);
    snd4 = 1'b1; cmd4 = 32'h01020304; step(); snd4 = 1'b0;
    frame_timing("nb4", FRAME4);
    repeat (4) step();
    check_eq("nb4_left", exp_q.size(), 0);
    c = $urandom;
    expect_cmd(c, 4);
    snd4 = 1'b1; cmd4 = c; step(); snd4 = 1'b0;
    wait_idle("nb4r", 2 * FRAME4);
    check_eq("nb4_ncmplt", cmplt_n - c0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
